dm_cache_ctrl: RTL and testbench

Controller FSM for the direct-mapped cache. It accepts one CPU word request at a time and drives the single-port tag memory and line data memory: index, write enable and write value out; combinational read value back. On a miss it moves whole lines to and from the next memory level, with write-back of dirty victims and write-allocate on write misses.

---
 rtl/dm_cache_ctrl.sv | 130 +++++++++++++
 tb/tb_dm_cache_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: CPU word requests against a single-port tag/data
// store, with dirty write-back and write-allocate line transfers to the next level.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 128,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = ADDR_W - INDEX_W - 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    input  logic               cpu_rw,
    input  logic               cpu_valid,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    output logic               mem_rw,
    output logic               mem_valid,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic [INDEX_W-1:0] tag_index,
    output logic               tag_we,
    output logic [TAG_W+1:0]   tag_wr,
    input  logic [TAG_W+1:0]   tag_rd,
    output logic [INDEX_W-1:0] data_index,
    output logic               data_we,
    output logic [LINE_W-1:0]  data_wr,
    input  logic [LINE_W-1:0]  data_rd
);
    localparam int OFF_W = 4;
    localparam int WORDS = LINE_W / WORD_W;
    localparam int SEL_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              rw;
    } req_t;

    state_t state, state_nxt;
    req_t   req;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [SEL_W-1:0]   word_sel;
    logic               rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]   rd_tag;

    assign req_tag  = req.addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req.addr[OFF_W +: INDEX_W];
    assign word_sel = req.addr[2 +: SEL_W];

    assign {rd_valid, rd_dirty, rd_tag} = tag_rd;
    assign hit = rd_valid && (rd_tag == req_tag);

    assign tag_index  = req_idx;
    assign data_index = req_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_valid)
                req <= {cpu_addr, cpu_wdata, cpu_rw};
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_rdata = '0;
        cpu_ready = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        mem_valid = 1'b0;
        tag_we    = 1'b0;
        tag_wr    = '0;
        data_we   = 1'b0;
        data_wr   = '0;
        case (state)
            IDLE: if (cpu_valid) state_nxt = COMPARE;
            COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    state_nxt = IDLE;
                    if (req.rw) begin
                        data_we = 1'b1;
                        data_wr = data_rd;
                        data_wr[WORD_W*int'(word_sel) +: WORD_W] = req.wdata;
                        tag_we  = 1'b1;
                        tag_wr  = {2'b11, req_tag};
                    end else begin
                        cpu_rdata = data_rd[WORD_W*int'(word_sel) +: WORD_W];
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_nxt = WRITE_BACK;
                end else begin
                    state_nxt = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                // victim address comes from the stored tag, not the request
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {rd_tag, req_idx, {OFF_W{1'b0}}};
                mem_wdata = data_rd;
                if (mem_ready) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    data_we   = 1'b1;
                    data_wr   = mem_rdata;
                    tag_we    = 1'b1;
                    tag_wr    = {2'b10, req_tag};
                    state_nxt = COMPARE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: behavioural tag/data arrays, a next-level memory responder,
// a table of CPU requests with expected data/latency/tag state, and a reset-mid-miss sequence.
module tb_dm_cache_ctrl;
    localparam int ADDR_W = 32, WORD_W = 32, LINE_W = 128, INDEX_W = 3, TAG_W = 25;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [WORD_W-1:0]  cpu_wdata;
    logic               cpu_rw, cpu_valid;
    logic [WORD_W-1:0]  cpu_rdata;
    logic               cpu_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]  mem_wdata, mem_rdata;
    logic               mem_rw, mem_valid, mem_ready;
    logic [INDEX_W-1:0] tag_index, data_index;
    logic               tag_we, data_we;
    logic [TAG_W+1:0]   tag_wr, tag_rd;
    logic [LINE_W-1:0]  data_wr, data_rd;

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W),
                    .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_valid(cpu_valid),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .tag_index(tag_index), .tag_we(tag_we), .tag_wr(tag_wr), .tag_rd(tag_rd),
        .data_index(data_index), .data_we(data_we), .data_wr(data_wr), .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    // tag/data arrays
    logic [TAG_W+1:0]  tmem [8];
    logic [LINE_W-1:0] dmem [8];
    logic              mem_clr;
    int                tag_wr_cnt, data_wr_cnt, ready_cnt;

    assign tag_rd  = tmem[tag_index];
    assign data_rd = dmem[data_index];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) begin
                tmem[i] <= '0;
                dmem[i] <= '0;
            end
            tag_wr_cnt  <= 0;
            data_wr_cnt <= 0;
            ready_cnt   <= 0;
        end else begin
            if (tag_we) begin
                tmem[tag_index] <= tag_wr;
                tag_wr_cnt <= tag_wr_cnt + 1;
            end
            if (data_we) begin
                dmem[data_index] <= data_wr;
                data_wr_cnt <= data_wr_cnt + 1;
            end
            if (cpu_ready) ready_cnt <= ready_cnt + 1;
        end
    end

    // next-level memory: responds 3 cycles after mem_valid, logs every transfer
    logic [LINE_W-1:0] bmem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] wb_addr_q[$], fill_q[$];
    logic [LINE_W-1:0] wb_data_q[$];
    logic auto_mem;
    int   pulse_req, pulse_done;

    initial begin
        int cnt;
        cnt = 0;
        pulse_done = 0;
        bmem[32'h40]  = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        bmem[32'hC0]  = {32'h3333_0C0C, 32'h2222_0C0C, 32'h1111_0C0C, 32'h0000_0C0C};
        bmem[32'h100] = {32'h3333_0100, 32'h2222_0100, 32'h1111_0100, 32'h0000_0100};
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (pulse_done != pulse_req) begin
                mem_ready = 1'b1;
                mem_rdata = {4{32'hBAD0_BAD0}};
                pulse_done++;
            end else if (auto_mem && mem_valid) begin
                cnt++;
                if (cnt >= 3) begin
                    mem_ready = 1'b1;
                    if (mem_rw) begin
                        bmem[mem_addr] = mem_wdata;
                        wb_addr_q.push_back(mem_addr);
                        wb_data_q.push_back(mem_wdata);
                    end else begin
                        mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : '0;
                        fill_q.push_back(mem_addr);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic do_req(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rw, input logic [31:0] rdata, input int lat);
        exp_t        e;
        int          seen;
        logic [31:0] rd_seen;
        sb.push_back('{rw, rdata, lat});
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_rw    = rw;
        cpu_valid = 1'b1;
        seen    = 0;
        rd_seen = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen    = n;
                rd_seen = cpu_rdata;
                break;
            end
        end
        cpu_valid = 1'b0;
        e = sb.pop_front();
        if (seen == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: no cpu_ready within 60 cycles", name);
        end else begin
            chk({name, " latency"}, 128'(seen), 128'(e.lat));
            if (!e.rw) chk({name, " rdata"}, 128'(rd_seen), 128'(e.rdata));
        end
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic             rw;
        logic [31:0]      rdata;
        int               lat;
        logic [TAG_W+1:0] tag;
    } vec_t;
    vec_t vecs[11];

    logic [ADDR_W-1:0] exp_fill[7];

    initial begin
        int t0, d0, r0, mv_seen, got;
        logic [2:0] vi;

        vecs[0]  = '{32'h40,  32'h0,         1'b0, 32'hAAAA_AAAA, 5, {2'b10, 25'd0}};
        vecs[1]  = '{32'h44,  32'h0,         1'b0, 32'hBBBB_BBBB, 1, {2'b10, 25'd0}};
        vecs[2]  = '{32'h48,  32'hDEAD_BEEF, 1'b1, 32'h0,         1, {2'b11, 25'd0}};
        vecs[3]  = '{32'hC0,  32'h0,         1'b0, 32'h0000_0C0C, 9, {2'b10, 25'd1}};
        vecs[4]  = '{32'h100, 32'h1234_5678, 1'b1, 32'h0,         5, {2'b11, 25'd2}};
        vecs[5]  = '{32'h104, 32'h0,         1'b0, 32'h1111_0100, 1, {2'b11, 25'd2}};
        vecs[6]  = '{32'h100, 32'h0,         1'b0, 32'h1234_5678, 1, {2'b11, 25'd2}};
        vecs[7]  = '{32'h48,  32'h0,         1'b0, 32'hDEAD_BEEF, 5, {2'b10, 25'd0}};
        vecs[8]  = '{32'h1C4, 32'hCAFE_F00D, 1'b1, 32'h0,         5, {2'b11, 25'd3}};
        vecs[9]  = '{32'hC0,  32'h0,         1'b0, 32'h0000_0C0C, 9, {2'b10, 25'd1}};
        vecs[10] = '{32'h1C4, 32'h0,         1'b0, 32'hCAFE_F00D, 5, {2'b10, 25'd3}};
        exp_fill = '{32'h40, 32'hC0, 32'h100, 32'h40, 32'h1C0, 32'hC0, 32'h1C0};

        pulse_req = 0;
        auto_mem  = 1'b1;
        mem_clr   = 1'b1;
        rst       = 1'b1;
        cpu_addr  = 32'h1C4;
        cpu_wdata = 32'hFFFF_FFFF;
        cpu_rw    = 1'b1;
        cpu_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset outputs", 128'(|{cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rw, mem_valid,
                                    tag_index, tag_we, tag_wr, data_index, data_we, data_wr}), 128'd0);
        cpu_valid = 1'b0;
        rst       = 1'b0;
        mem_clr   = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_req($sformatf("v%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].rw,
                   vecs[i].rdata, vecs[i].lat);
            @(posedge clk);
            #1;
            vi = vecs[i].addr[6:4];
            chk($sformatf("v%0d tag", i), 128'(tmem[vi]), 128'(vecs[i].tag));
        end

        chk("ready pulses", 128'(ready_cnt), 128'd11);
        chk("wb count", 128'(wb_addr_q.size()), 128'd2);
        if (wb_addr_q.size() >= 2) begin
            chk("wb0 addr", 128'(wb_addr_q[0]), 128'h40);
            chk("wb0 word2", 128'(wb_data_q[0][95:64]), 128'hDEAD_BEEF);
            chk("wb1 addr", 128'(wb_addr_q[1]), 128'h1C0);
            chk("wb1 word1", 128'(wb_data_q[1][63:32]), 128'hCAFE_F00D);
        end
        chk("fill count", 128'(fill_q.size()), 128'd7);
        if (fill_q.size() == 7)
            for (int i = 0; i < 7; i++)
                chk($sformatf("fill%0d addr", i), 128'(fill_q[i]), 128'(exp_fill[i]));

        // reset while a line fill is outstanding; the late mem_ready must be ignored
        auto_mem = 1'b0;
        @(negedge clk);
        cpu_addr  = 32'h210;
        cpu_rw    = 1'b0;
        cpu_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_valid && !mem_rw) begin
                got = 1;
                break;
            end
        end
        chk("rst: reached ALLOCATE", 128'(got), 128'd1);
        chk("rst: fill addr", 128'(mem_addr), 128'h210);
        t0 = tag_wr_cnt;
        d0 = data_wr_cnt;
        r0 = ready_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst: outputs cleared", 128'(|{cpu_ready, mem_valid, mem_addr, tag_we, data_we, tag_index}), 128'd0);
        cpu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulse_req++;
        mv_seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (mem_valid || cpu_ready) mv_seen++;
        end
        chk("rst: idle after late mem_ready", 128'(mv_seen), 128'd0);
        chk("rst: no tag write", 128'(tag_wr_cnt), 128'(t0));
        chk("rst: no data write", 128'(data_wr_cnt), 128'(d0));
        chk("rst: no ready", 128'(ready_cnt), 128'(r0));
        chk("rst: tag1 untouched", 128'(tmem[1]), 128'd0);
        chk("rst: tag4 kept", 128'(tmem[4]), 128'({2'b10, 25'd3}));

        auto_mem = 1'b1;
        do_req("post-reset hit", 32'h1C4, 32'h0, 1'b0, 32'hCAFE_F00D, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
